datapath: RTL and testbench
===========================

# datapath

Single-bus 32-bit CPU datapath. Holds the general registers R1–R3, plus PC, IR, MAR, MDR, Y and a 64-bit Z (ZHigh/ZLow), all joined by one shared bus. A minimal ALU sits between Y, the bus and Z. It is driven cycle-by-cycle by the control unit (or a bench FSM) through discrete `*out`/`*in` strobes, and sits below the control unit and above memory.

## Interface
Parameters:
- none; data width is fixed at 32 bits.

Ports:
- One clock; reset is asynchronous and active-high.
- clock  in  1  system clock; all registers load on the rising edge.
- reset  in  1  asynchronous, active-high; clears every register.
- PCout, Zlowout, MDRout, R2out, R3out  in  1 each  bus-source selects.
- MARin, Zin, PCin, MDRin, IRin, Yin, R1in, R2in, R3in  in  1 each  register load enables.
- IncPC  in  1  ALU op: Z ← bus + 1.
- Read  in  1  MDR input mux: 1 selects Mdatain, 0 selects bus.
- My_AND  in  1  ALU op: Z ← Y & bus.
- Mdatain  in  32  memory read data.
- Bus  out  32  current bus value (combinational).
- R1, R2, R3, PC, IR, MAR, MDR, Y, ZLow, ZHigh  out  32 each  register contents.
- Positional order: PCout, Zlowout, MDRout, R2out, R3out, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, My_AND, R1in, R2in, R3in, clock, Mdatain, reset, then outputs in the order listed.

## Operation
- Bus is combinational.
  - Source priority: PCout > Zlowout > MDRout > R2out > R3out.
  - With no source asserted, Bus = 0.
- MDR input mux: Read ? Mdatain : Bus. MDR loads that value when MDRin = 1.
- PC, IR, MAR, Y, R1, R2, R3 each load Bus when their `*in` strobe is 1; otherwise they hold.
- ALU is combinational. Op priority: IncPC > My_AND > ADD (default).
  - IncPC: ZLow = Bus + 1 (mod 2^32); ZHigh = 0.
  - My_AND: ZLow = Y & Bus; ZHigh = 0.
  - ADD: {ZHigh, ZLow} = zero-extended Y + Bus, so ZHigh[0] is the carry-out and ZHigh[31:1] = 0.
- Z (ZHigh and ZLow together) loads the ALU result when Zin = 1.
- Several `*in` strobes in one cycle all load the same Bus value. A register may be both source and destination in the same cycle; it reads its old value and stores the new one.

## Timing
- Load latency is 1 cycle: a value on Bus at a rising edge with the strobe high is visible on the register output immediately after that edge.
- Bus and ALU respond combinationally to strobe changes within the same cycle; there is no handshake.
- Reset (asynchronous, active-high) clears all registers to 0 immediately.
  - Reset asserted mid-instruction aborts it; strobes are ignored while reset is high.
  - Loading resumes on the first rising edge after reset deasserts.
- Strobes must be stable around the rising edge. Glitches between edges have no effect.

## Configuration
- Macro `DATAPATH_BUS_CHECK_EN`.
- Defined: adds output `bus_conflict` (1 bit, combinational), which is high when more than one bus-source select is asserted. A simulation-only assertion also prints an error at each rising edge where `bus_conflict` = 1. Bus priority is unchanged.
- Undefined: no `bus_conflict` port and no check; priority resolution alone applies.

## Structure
- Shared package `datapath_pkg`: width constant `DATA_W` = 32, and the ALU op enum {ALU_ADD, ALU_AND, ALU_INC}.
- Sub-module `datapath_reg32`: 32-bit register with async active-high clear and a load enable. It is instantiated for every 32-bit register; ZHigh/ZLow use two instances.
- Bus mux, MDR mux and ALU are coded inline in `datapath`.

## Test plan
- Register load: Mdatain=0x12, Read=MDRin=1 for one cycle, then MDRout=R2in=1 -> R2=0x12. Repeat to get R3=0x14 and R1=0x18.
- Fetch, starting from reset (PC=0):
  - T0 (PCout, MARin, IncPC, Zin) -> MAR=0, ZLow=1.
  - T1 (Zlowout, PCin, Read, MDRin, Mdatain=0x28918000) -> PC=1, MDR=0x28918000.
  - T2 (MDRout, IRin) -> IR=0x28918000.
- AND R1,R2,R3:
  - T3 (R2out, Yin) -> Y=0x12.
  - T4 (R3out, My_AND, Zin) -> ZLow=0x10, ZHigh=0.
  - T5 (Zlowout, R1in) -> R1=0x10.
- ADD carry: Y=0xFFFFFFFF, R3out with Zin, no op strobe -> ZLow=0xFFFFFFFE, ZHigh=1.
- Bus idle and priority:
  - no `*out` asserted -> Bus=0.
  - PCout=R2out=1 -> Bus=PC; with the macro defined, bus_conflict=1.
- Async reset: assert reset between edges after R1=0x10 -> all registers read 0 before the next edge; R2in ignored while reset is high.

Source files
------------

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared width constant and ALU op encoding for the datapath
package datapath_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_AND = 2'd1,
        ALU_INC = 2'd2
    } alu_op_e;

endpackage

// File: rtl/datapath_reg32.sv
// rtl/datapath_reg32.sv - 32-bit register with load enable and async active-high clear
import datapath_pkg::*;

module datapath_reg32 (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (ld) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - single-bus 32-bit CPU datapath: registers, shared bus, minimal ALU
// Optional DATAPATH_BUS_CHECK_EN adds a bus_conflict output and a multi-driver check.
import datapath_pkg::*;

module datapath (
    input  logic              PCout,
    input  logic              Zlowout,
    input  logic              MDRout,
    input  logic              R2out,
    input  logic              R3out,
    input  logic              MARin,
    input  logic              Zin,
    input  logic              PCin,
    input  logic              MDRin,
    input  logic              IRin,
    input  logic              Yin,
    input  logic              IncPC,
    input  logic              Read,
    input  logic              My_AND,
    input  logic              R1in,
    input  logic              R2in,
    input  logic              R3in,
    input  logic              clock,
    input  logic [DATA_W-1:0] Mdatain,
    input  logic              reset,
    output logic [DATA_W-1:0] Bus,
    output logic [DATA_W-1:0] R1,
    output logic [DATA_W-1:0] R2,
    output logic [DATA_W-1:0] R3,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] MAR,
    output logic [DATA_W-1:0] MDR,
    output logic [DATA_W-1:0] Y,
    output logic [DATA_W-1:0] ZLow,
    output logic [DATA_W-1:0] ZHigh
`ifdef DATAPATH_BUS_CHECK_EN
    ,
    output logic              bus_conflict
`endif
);

    logic [DATA_W-1:0]   mdr_mux;
    logic [2*DATA_W-1:0] alu_result;
    alu_op_e             alu_op;

    // Fixed-priority bus source select; an idle bus reads as zero.
    always_comb begin
        Bus = '0;
        if (PCout) begin
            Bus = PC;
        end else if (Zlowout) begin
            Bus = ZLow;
        end else if (MDRout) begin
            Bus = MDR;
        end else if (R2out) begin
            Bus = R2;
        end else if (R3out) begin
            Bus = R3;
        end
    end

    assign mdr_mux = Read ? Mdatain : Bus;

    always_comb begin
        alu_op = ALU_ADD;
        if (IncPC) begin
            alu_op = ALU_INC;
        end else if (My_AND) begin
            alu_op = ALU_AND;
        end
    end

    // ADD keeps the carry-out in bit 0 of the high word.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_INC: alu_result = {{DATA_W{1'b0}}, Bus + 32'd1};
            ALU_AND: alu_result = {{DATA_W{1'b0}}, Y & Bus};
            default: alu_result = {{DATA_W{1'b0}}, Y} + {{DATA_W{1'b0}}, Bus};
        endcase
    end

    datapath_reg32 u_pc    (.clk(clock), .rst(reset), .ld(PCin),  .d(Bus),     .q(PC));
    datapath_reg32 u_ir    (.clk(clock), .rst(reset), .ld(IRin),  .d(Bus),     .q(IR));
    datapath_reg32 u_mar   (.clk(clock), .rst(reset), .ld(MARin), .d(Bus),     .q(MAR));
    datapath_reg32 u_mdr   (.clk(clock), .rst(reset), .ld(MDRin), .d(mdr_mux), .q(MDR));
    datapath_reg32 u_y     (.clk(clock), .rst(reset), .ld(Yin),   .d(Bus),     .q(Y));
    datapath_reg32 u_r1    (.clk(clock), .rst(reset), .ld(R1in),  .d(Bus),     .q(R1));
    datapath_reg32 u_r2    (.clk(clock), .rst(reset), .ld(R2in),  .d(Bus),     .q(R2));
    datapath_reg32 u_r3    (.clk(clock), .rst(reset), .ld(R3in),  .d(Bus),     .q(R3));
    datapath_reg32 u_zlow  (.clk(clock), .rst(reset), .ld(Zin),
                            .d(alu_result[DATA_W-1:0]), .q(ZLow));
    datapath_reg32 u_zhigh (.clk(clock), .rst(reset), .ld(Zin),
                            .d(alu_result[2*DATA_W-1:DATA_W]), .q(ZHigh));

`ifdef DATAPATH_BUS_CHECK_EN
    logic [4:0] bus_srcs;

    assign bus_srcs     = {PCout, Zlowout, MDRout, R2out, R3out};
    assign bus_conflict = |(bus_srcs & (bus_srcs - 5'd1));

    bus_single_driver: assert property (@(posedge clock) !bus_conflict)
        else $error("datapath: more than one bus source selected");
`endif

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - self-checking bench: directed program plus randomized strobes vs a behavioural model
module tb_datapath;

    logic        clock = 1'b0;
    logic        reset;
    logic        PCout, Zlowout, MDRout, R2out, R3out;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin;
    logic        IncPC, Read, My_AND, R1in, R2in, R3in;
    logic [31:0] Mdatain;
    logic [31:0] Bus, R1, R2, R3, PC, IR, MAR, MDR, Y, ZLow, ZHigh;
`ifdef DATAPATH_BUS_CHECK_EN
    logic        bus_conflict;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_r1, m_r2, m_r3, m_pc, m_ir, m_mar, m_mdr, m_y, m_zl, m_zh;

    always #5 clock = ~clock;

    datapath dut (
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .R2out(R2out), .R3out(R3out),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .Read(Read), .My_AND(My_AND), .R1in(R1in), .R2in(R2in), .R3in(R3in),
        .clock(clock), .Mdatain(Mdatain), .reset(reset),
        .Bus(Bus), .R1(R1), .R2(R2), .R3(R3), .PC(PC), .IR(IR), .MAR(MAR), .MDR(MDR),
        .Y(Y), .ZLow(ZLow), .ZHigh(ZHigh)
`ifdef DATAPATH_BUS_CHECK_EN
        , .bus_conflict(bus_conflict)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_bus();
        if (PCout)   return m_pc;
        if (Zlowout) return m_zl;
        if (MDRout)  return m_mdr;
        if (R2out)   return m_r2;
        if (R3out)   return m_r3;
        return 32'd0;
    endfunction

    // Reference: arithmetic on whole 64-bit values, carry falls out naturally.
    function automatic logic [63:0] model_alu(input logic [31:0] b);
        longint unsigned s;
        if (IncPC) return {32'd0, b + 32'd1};
        if (My_AND) return {32'd0, m_y & b};
        s = longint'(m_y) + longint'(b);
        return s;
    endfunction

    always @(posedge clock or posedge reset) begin
        logic [31:0] b;
        logic [63:0] z;
        if (reset) begin
            {m_r1, m_r2, m_r3, m_pc, m_ir, m_mar, m_mdr, m_y, m_zl, m_zh} = '0;
        end else begin
            b = model_bus();
            z = model_alu(b);
            if (MARin) m_mar = b;
            if (PCin)  m_pc  = b;
            if (IRin)  m_ir  = b;
            if (Yin)   m_y   = b;
            if (R1in)  m_r1  = b;
            if (R2in)  m_r2  = b;
            if (R3in)  m_r3  = b;
            if (MDRin) m_mdr = Read ? Mdatain : b;
            if (Zin)   {m_zh, m_zl} = z;
        end
    end

    always @(negedge clock) begin
        check("bus",   {32'd0, Bus},   {32'd0, model_bus()});
        check("pc",    {32'd0, PC},    {32'd0, m_pc});
        check("ir",    {32'd0, IR},    {32'd0, m_ir});
        check("mar",   {32'd0, MAR},   {32'd0, m_mar});
        check("mdr",   {32'd0, MDR},   {32'd0, m_mdr});
        check("y",     {32'd0, Y},     {32'd0, m_y});
        check("r1",    {32'd0, R1},    {32'd0, m_r1});
        check("r2",    {32'd0, R2},    {32'd0, m_r2});
        check("r3",    {32'd0, R3},    {32'd0, m_r3});
        check("zlow",  {32'd0, ZLow},  {32'd0, m_zl});
        check("zhigh", {32'd0, ZHigh}, {32'd0, m_zh});
`ifdef DATAPATH_BUS_CHECK_EN
        check("bus_conflict", {63'd0, bus_conflict},
              {63'd0, (32'(PCout) + 32'(Zlowout) + 32'(MDRout) + 32'(R2out) + 32'(R3out)) > 1});
`endif
    end

    task automatic clr();
        {PCout, Zlowout, MDRout, R2out, R3out} = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin} = '0;
        {IncPC, Read, My_AND, R1in, R2in, R3in} = '0;
        Mdatain = 32'd0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        clr(); Mdatain = v; Read = 1; MDRin = 1; tick();
    endtask

    initial begin
        reset = 1'b1;
        clr();
        #1;
        check("reset_pc",   {32'd0, PC},   64'd0);
        check("reset_r1",   {32'd0, R1},   64'd0);
        check("reset_zlow", {32'd0, ZLow}, 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        load_mdr(32'h12); clr(); MDRout = 1; R2in = 1; tick();
        check("load_r2", {32'd0, R2}, 64'h12);
        load_mdr(32'h14); clr(); MDRout = 1; R3in = 1; tick();
        check("load_r3", {32'd0, R3}, 64'h14);
        load_mdr(32'h18); clr(); MDRout = 1; R1in = 1; tick();
        check("load_r1", {32'd0, R1}, 64'h18);

        clr(); PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
        check("t0_mar",  {32'd0, MAR},  64'h0);
        check("t0_zlow", {32'd0, ZLow}, 64'h1);
        clr(); Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h28918000; tick();
        check("t1_pc",  {32'd0, PC},  64'h1);
        check("t1_mdr", {32'd0, MDR}, 64'h28918000);
        clr(); MDRout = 1; IRin = 1; tick();
        check("t2_ir", {32'd0, IR}, 64'h28918000);

        clr(); R2out = 1; Yin = 1; tick();
        check("t3_y", {32'd0, Y}, 64'h12);
        clr(); R3out = 1; My_AND = 1; Zin = 1; tick();
        check("t4_zlow",  {32'd0, ZLow},  64'h10);
        check("t4_zhigh", {32'd0, ZHigh}, 64'h0);
        clr(); Zlowout = 1; R1in = 1; tick();
        check("t5_r1", {32'd0, R1}, 64'h10);

        load_mdr(32'hFFFF_FFFF);
        clr(); MDRout = 1; Yin = 1; R3in = 1; tick();
        clr(); R3out = 1; Zin = 1; tick();
        check("add_zlow",  {32'd0, ZLow},  64'hFFFF_FFFE);
        check("add_zhigh", {32'd0, ZHigh}, 64'h1);

        clr(); #1;
        check("bus_idle", {32'd0, Bus}, 64'h0);
        PCout = 1; R2out = 1; #1;
        check("bus_prio", {32'd0, Bus}, 64'h1);
`ifdef DATAPATH_BUS_CHECK_EN
        check("bus_conflict_set", {63'd0, bus_conflict}, 64'h1);
`endif
        clr();

        tick();
        MDRout = 1; R2in = 1;
        #2 reset = 1'b1;
        #1;
        check("rst_r1",   {32'd0, R1},    64'h0);
        check("rst_pc",   {32'd0, PC},    64'h0);
        check("rst_zh",   {32'd0, ZHigh}, 64'h0);
        tick();
        check("rst_r2_hold", {32'd0, R2}, 64'h0);
        reset = 1'b0;
        clr();

        for (int i = 0; i < 400; i++) begin
            clr();
`ifdef DATAPATH_BUS_CHECK_EN
            case ($urandom_range(0, 5))
                0: PCout = 1;
                1: Zlowout = 1;
                2: MDRout = 1;
                3: R2out = 1;
                4: R3out = 1;
                default: ;
            endcase
`else
            PCout   = ($urandom_range(0, 4) == 0);
            Zlowout = ($urandom_range(0, 3) == 0);
            MDRout  = ($urandom_range(0, 3) == 0);
            R2out   = ($urandom_range(0, 3) == 0);
            R3out   = ($urandom_range(0, 3) == 0);
`endif
            {MARin, Zin, PCin, MDRin, IRin, Yin} = 6'($urandom);
            {R1in, R2in, R3in, Read} = 4'($urandom);
            IncPC  = ($urandom_range(0, 3) == 0);
            My_AND = ($urandom_range(0, 2) == 0);
            Mdatain = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            reset = ($urandom_range(0, 60) == 0);
            tick();
        end
        reset = 1'b0;
        clr();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
